pll_clk_monitor: RTL



---
 rtl/pll_clk_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pll_clk_monitor.sv
// PLL lock/frequency monitor running on the free-running reference clock.
// Waits for a stable lock, counts toggle edges per window and gates the downstream reset.
module pll_clk_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int WIN_CYC         = 4096,
    parameter int EXP_EDGES       = 102,
    parameter int TOL             = 2,
    parameter int CNT_W           = 16,
    parameter int LOSS_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              mon_tgl,
    input  logic              clr_fault,
    output logic              rst_out_n,
    output logic              pll_ok,
    output logic              fault,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  meas_count,
    output logic [LOSS_W-1:0] loss_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_STAB  = 3'd1,
        ST_MEAS  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] PASS_LO   = CNT_W'(EXP_EDGES - TOL);
    localparam logic [CNT_W-1:0] PASS_HI   = CNT_W'(EXP_EDGES + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_lock_sync;
    logic [SYNC_STAGES-1:0]  r_tgl_sync;
    logic                    r_tgl_prev;
    logic [CNT_W-1:0]        r_stab_cnt;
    logic [CNT_W-1:0]        r_win_cnt;
    logic [CNT_W-1:0]        r_edge_cnt;
    logic [CNT_W-1:0]        r_meas_count;
    logic [LOSS_W-1:0]       r_loss_cnt;
    logic                    r_meas_valid;
    logic                    r_rst_out_n;
    logic                    r_pll_ok;
    logic                    r_fault;

    logic                    w_lock_s;
    logic                    w_tgl_s;
    logic                    w_edge;
    logic                    w_in_window;
    logic                    w_win_end;
    logic [CNT_W-1:0]        w_edge_sum;
    logic                    w_pass;

    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_tgl_s     = r_tgl_sync[SYNC_STAGES-1];
    assign w_edge      = w_tgl_s ^ r_tgl_prev;
    assign w_in_window = (r_state == ST_MEAS) || (r_state == ST_RUN);
    assign w_win_end   = w_in_window && (r_win_cnt == WIN_LAST);

    // Edge total including this cycle's edge, saturating at all ones.
    assign w_edge_sum  = (r_edge_cnt == CNT_MAX) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);
    assign w_pass      = (w_edge_sum >= PASS_LO) && (w_edge_sum <= PASS_HI);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT: begin
                if (w_lock_s) w_state_next = ST_STAB;
            end
            ST_STAB: begin
                if (!w_lock_s)                    w_state_next = ST_WAIT;
                else if (r_stab_cnt == STAB_LAST) w_state_next = ST_MEAS;
            end
            ST_MEAS: begin
                if (!w_lock_s)      w_state_next = ST_WAIT;
                else if (w_win_end) w_state_next = w_pass ? ST_RUN : ST_FAULT;
            end
            ST_RUN: begin
                // Lock loss takes priority over a failing window end.
                if (!w_lock_s)                 w_state_next = ST_WAIT;
                else if (w_win_end && !w_pass) w_state_next = ST_FAULT;
            end
            ST_FAULT: begin
                if (clr_fault) w_state_next = ST_WAIT;
            end
            default: w_state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT;
            r_lock_sync  <= '0;
            r_tgl_sync   <= '0;
            r_tgl_prev   <= 1'b0;
            r_stab_cnt   <= '0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_meas_count <= '0;
            r_loss_cnt   <= '0;
            r_meas_valid <= 1'b0;
            r_rst_out_n  <= 1'b0;
            r_pll_ok     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_lock_sync  <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
            r_tgl_sync   <= {r_tgl_sync[SYNC_STAGES-2:0], mon_tgl};
            r_tgl_prev   <= w_tgl_s;
            r_state      <= w_state_next;
            r_rst_out_n  <= (w_state_next == ST_RUN);
            r_pll_ok     <= (w_state_next == ST_RUN);
            r_fault      <= (w_state_next == ST_FAULT);
            r_meas_valid <= w_win_end;

            if (w_win_end) r_meas_count <= w_edge_sum;

            if (r_state == ST_STAB) r_stab_cnt <= r_stab_cnt + 1'b1;
            else                    r_stab_cnt <= '0;

            // Windows run back-to-back; counters are held at zero outside MEAS/RUN.
            if (w_in_window && !w_win_end) begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_edge_cnt <= w_edge_sum;
            end else begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
            end

            if ((r_state == ST_RUN) && !w_lock_s && (r_loss_cnt != {LOSS_W{1'b1}}))
                r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign rst_out_n  = r_rst_out_n;
    assign pll_ok     = r_pll_ok;
    assign fault      = r_fault;
    assign meas_valid = r_meas_valid;
    assign meas_count = r_meas_count;
    assign loss_cnt   = r_loss_cnt;
    assign state      = r_state;

endmodule
